// File: rtl/siso_chain_ctrl.sv
// siso_chain_ctrl: serialises a parallel word into an external SISO register
// chain of known latency, reassembles the bits returning from the chain and
// flags whether the returned word equals the word sent (chain loopback check).
module siso_chain_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             ser_out,
  input  logic             ser_in,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_match
);

  localparam int TOT = WIDTH + DEPTH;
  localparam int CW  = $clog2(TOT);
  localparam logic [CW-1:0] LAST_TX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST    = CW'(TOT - 1);
  localparam logic [CW-1:0] CAP_LO  = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

  state_t           state, nstate;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tsr;      // bits still to be sent, head at the shift-out end
  logic [WIDTH-1:0] tx_copy;  // word as accepted, kept for the integrity compare
  logic [WIDTH-1:0] rsr;      // returning bits being assembled
  logic             ser_q;

  logic             tx_head, tsr_head, cap;
  logic [WIDTH-1:0] tx_rest, tsr_rest, rsr_nxt;

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign rx_valid = (state == DONE);
  assign ser_out  = ser_q;

  // Bit-order helpers: which bit leaves first, what remains, how returns pack.
  always_comb begin
    if (LSB_FIRST) begin
      tx_head  = tx_data[0];
      tx_rest  = {1'b0, tx_data[WIDTH-1:1]};
      tsr_head = tsr[0];
      tsr_rest = {1'b0, tsr[WIDTH-1:1]};
      rsr_nxt  = {ser_in, rsr[WIDTH-1:1]};
    end else begin
      tx_head  = tx_data[WIDTH-1];
      tx_rest  = {tx_data[WIDTH-2:0], 1'b0};
      tsr_head = tsr[WIDTH-1];
      tsr_rest = {tsr[WIDTH-2:0], 1'b0};
      rsr_nxt  = {rsr[WIDTH-2:0], ser_in};
    end
    // The bit sent at cnt=k comes back at cnt=k+DEPTH; cnt never passes LAST.
    cap = ((state == SHIFT) || (state == FLUSH)) && (cnt >= CAP_LO);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state: SHIFT for WIDTH cycles, FLUSH until the last return bit, DONE once.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (tx_valid)       nstate = SHIFT;
      SHIFT: if (cnt == LAST_TX) nstate = FLUSH;
      FLUSH: if (cnt == LAST)    nstate = DONE;
      DONE:                      nstate = IDLE;
      default:                   nstate = IDLE;
    endcase
  end

  // Transmit side and cycle counter; ser_out is registered so the first bit
  // appears in the cycle right after the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      tsr     <= '0;
      tx_copy <= '0;
      ser_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ser_q <= 1'b0;
          if (tx_valid) begin
            tsr     <= tx_rest;
            tx_copy <= tx_data;
            ser_q   <= tx_head;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          cnt   <= cnt + CW'(1);
          tsr   <= tsr_rest;
          ser_q <= (cnt == LAST_TX) ? 1'b0 : tsr_head;
        end
        FLUSH: begin
          ser_q <= 1'b0;
          cnt   <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
        default: ser_q <= 1'b0;
      endcase
    end
  end

  // Receive side: assemble in the capture window, publish on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsr      <= '0;
      rx_data  <= '0;
      rx_match <= 1'b0;
    end else if (cap) begin
      rsr <= rsr_nxt;
      if (cnt == LAST) begin
        rx_data  <= rsr_nxt;
        rx_match <= (rsr_nxt == tx_copy);
      end
    end
  end

endmodule

// File: tb/tb_siso_chain_ctrl.sv
// tb_siso_chain_ctrl: three controller configurations (8/4 MSB-first,
// 8/4 LSB-first, 4/10 MSB-first), each looped through its own DEPTH-flop chain
// model with optional inversion, driven by directed and random transfers.
module tb_siso_chain_ctrl;

  logic            clk;
  logic [2:0]      rst;
  logic [2:0]      tx_valid, tx_ready, ser_out, ser_in, busy, rx_valid, rx_match;
  logic [2:0][7:0] tx_data, rx_data;
  logic [2:0]      inv;
  logic [9:0]      ch [3];
  int              n_chk, n_fail, cyc, t_acc;

  siso_chain_ctrl #(.WIDTH(8), .DEPTH(4), .LSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .ser_out(ser_out[0]), .ser_in(ser_in[0]),
    .busy(busy[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_match(rx_match[0]));

  siso_chain_ctrl #(.WIDTH(8), .DEPTH(4), .LSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .ser_out(ser_out[1]), .ser_in(ser_in[1]),
    .busy(busy[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_match(rx_match[1]));

  siso_chain_ctrl #(.WIDTH(4), .DEPTH(10), .LSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst[2]), .tx_data(tx_data[2][3:0]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .ser_out(ser_out[2]), .ser_in(ser_in[2]),
    .busy(busy[2]), .rx_data(rx_data[2][3:0]), .rx_valid(rx_valid[2]), .rx_match(rx_match[2]));

  assign rx_data[2][7:4] = 4'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Chain models: DEPTH flops from ser_out to ser_in, optionally inverting.
  always @(posedge clk)
    for (int u = 0; u < 3; u++) ch[u] <= {ch[u][8:0], ser_out[u]};

  assign ser_in[0] = ch[0][3] ^ inv[0];
  assign ser_in[1] = ch[1][3] ^ inv[1];
  assign ser_in[2] = ch[2][9] ^ inv[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int wid(input int u);  return (u == 2) ? 4 : 8;  endfunction
  function automatic int dep(input int u);  return (u == 2) ? 10 : 4; endfunction

  task automatic chk_idle_reset(input int u);
    chk($sformatf("u%0d rst tx_ready", u), tx_ready[u], 1);
    chk($sformatf("u%0d rst busy", u),     busy[u],     0);
    chk($sformatf("u%0d rst ser_out", u),  ser_out[u],  0);
    chk($sformatf("u%0d rst rx_valid", u), rx_valid[u], 0);
    chk($sformatf("u%0d rst rx_data", u),  rx_data[u],  0);
    chk($sformatf("u%0d rst rx_match", u), rx_match[u], 0);
  endtask

  // One transfer, checked cycle by cycle against the ideal timeline.
  // Called and returns at a negedge with instance u idle.
  // mode 0: tx_valid low while busy; 1: random tx_valid/tx_data while busy;
  // 2: tx_valid held high with tx_data=nxt while busy.
  task automatic send(input int u, input logic [7:0] word_in, input int mode,
                      input logic [7:0] nxt);
    int w, d;
    bit lsb, eb;
    logic [7:0] mask, word, exp_rx;
    w = wid(u); d = dep(u); lsb = (u == 1);
    mask   = 8'((1 << w) - 1);
    word   = word_in & mask;
    exp_rx = inv[u] ? (~word & mask) : word;
    chk($sformatf("u%0d pre tx_ready", u), tx_ready[u], 1);
    tx_data[u]  = word;
    tx_valid[u] = 1'b1;
    @(posedge clk);
    t_acc = cyc;
    @(negedge clk);
    for (int k = 0; k < w + d; k++) begin
      eb = (k < w) ? (lsb ? word[k] : word[w-1-k]) : 1'b0;
      chk($sformatf("u%0d ser_out k%0d", u, k), ser_out[u], eb);
      chk($sformatf("u%0d tx_ready k%0d", u, k), tx_ready[u], 0);
      chk($sformatf("u%0d busy k%0d", u, k), busy[u], 1);
      chk($sformatf("u%0d rx_valid k%0d", u, k), rx_valid[u], 0);
      case (mode)
        1:       begin tx_valid[u] = 1'($urandom); tx_data[u] = 8'($urandom); end
        2:       begin tx_valid[u] = 1'b1; tx_data[u] = nxt; end
        default: tx_valid[u] = 1'b0;
      endcase
      @(negedge clk);
    end
    chk($sformatf("u%0d done rx_valid", u), rx_valid[u], 1);
    chk($sformatf("u%0d done rx_data", u),  rx_data[u],  exp_rx);
    chk($sformatf("u%0d done rx_match", u), rx_match[u], (exp_rx == word));
    chk($sformatf("u%0d done busy", u),     busy[u],     1);
    chk($sformatf("u%0d done tx_ready", u), tx_ready[u], 0);
    tx_valid[u] = 1'b0;
    @(negedge clk);
    chk($sformatf("u%0d post tx_ready", u), tx_ready[u], 1);
    chk($sformatf("u%0d post rx_valid", u), rx_valid[u], 0);
    chk($sformatf("u%0d post rx_data", u),  rx_data[u],  exp_rx);
    chk($sformatf("u%0d post busy", u),     busy[u],     0);
  endtask

  // Start a transfer and reset it in cycle 'at'; no result may ever appear.
  task automatic abort(input int u, input logic [7:0] word, input int at);
    tx_data[u]  = word;
    tx_valid[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid[u] = 1'b0;
    for (int k = 0; k < at; k++) @(negedge clk);
    chk($sformatf("u%0d abort busy", u), busy[u], 1);
    rst[u] = 1'b1;
    @(negedge clk);
    rst[u] = 1'b0;
    chk_idle_reset(u);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("u%0d abort rx_valid k%0d", u, k), rx_valid[u], 0);
    end
  endtask

  initial begin
    int u, t0;
    n_chk = 0; n_fail = 0; cyc = 0;
    rst = 3'b111; tx_valid = '0; tx_data = '0; inv = '0;
    for (int i = 0; i < 3; i++) ch[i] = '0;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle_reset(i);
    rst = 3'b000;
    @(negedge clk);

    send(0, 8'hB5, 0, 8'h00);
    send(0, 8'h3C, 2, 8'hC3);
    t0 = t_acc;
    send(0, 8'hC3, 0, 8'h00);
    chk("u0 accept spacing", t_acc - t0, 14);
    inv[0] = 1'b1;
    send(0, 8'hB5, 0, 8'h00);
    inv[0] = 1'b0;
    abort(0, 8'hFF, 3);
    send(0, 8'h81, 0, 8'h00);
    send(1, 8'h01, 0, 8'h00);
    send(2, 8'h0A, 1, 8'h00);

    for (int i = 0; i < 40; i++) begin
      u = int'($urandom_range(0, 2));
      inv[u] = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(u, 8'($urandom), int'($urandom_range(0, 2)), 8'($urandom));
      inv[u] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
